// File: rtl/sr_sched_pkg.sv
// Shared types and default sizes for the shift-register load scheduler.
package sr_sched_pkg;

   localparam int unsigned SIZESRDYN_DEF  = 16;
   localparam int unsigned SIZESRSTAT_DEF = 88;

   typedef enum logic [2:0] {
      SETTLE,
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } state_e;

   typedef enum logic {
      DYN,
      STAT
   } grant_e;

endpackage

// File: rtl/sr_load_scheduler_if.sv
// Requester handshakes plus serial shift-register pins of the load scheduler.
interface sr_load_scheduler_if
   import sr_sched_pkg::*;
#(
   parameter int unsigned SIZESRDYN  = SIZESRDYN_DEF,
   parameter int unsigned SIZESRSTAT = SIZESRSTAT_DEF
);
   logic                  dyn_req;
   logic [SIZESRDYN-1:0]  dyn_data;
   logic                  dyn_ack;
   logic                  stat_req;
   logic [SIZESRSTAT-1:0] stat_data;
   logic                  stat_ack;
   logic                  SEL;
   logic                  MOSI;
   logic                  SCLK;
   logic                  busy;
   logic                  done_dyn;
   logic                  done_stat;

   // Requester / shift-register side
   modport master (
      output dyn_req, dyn_data, stat_req, stat_data,
      input  dyn_ack, stat_ack, SEL, MOSI, SCLK, busy, done_dyn, done_stat
   );

   // Scheduler side
   modport slave (
      input  dyn_req, dyn_data, stat_req, stat_data,
      output dyn_ack, stat_ack, SEL, MOSI, SCLK, busy, done_dyn, done_stat
   );

endinterface

// File: rtl/sr_bit_timer.sv
// Half-period counter generating SCLK and per-bit start/end strobes.
module sr_bit_timer
   import sr_sched_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic sclk_o,
   output logic bit_start_c,
   output logic bit_end_c
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic          phase_q;
   logic          half_last_c;

   assign half_last_c = (cnt_q == CW'(CLK_DIV - 1));

   // Count CLK cycles in each half bit; phase is the SCLK level (low half first)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (!en_i) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (half_last_c) begin
         cnt_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         cnt_q   <= cnt_q + CW'(1);
      end
   end

   assign sclk_o      = phase_q;
   assign bit_start_c = en_i & ~phase_q & (cnt_q == '0);
   assign bit_end_c   = en_i & phase_q & half_last_c;

endmodule

// File: rtl/sr_load_scheduler.sv
// Round-robin arbiter and MSB-first serialiser for the dynamic/static shift registers.
module sr_load_scheduler
   import sr_sched_pkg::*;
#(
   parameter int unsigned SIZESRDYN     = SIZESRDYN_DEF,
   parameter int unsigned SIZESRSTAT    = SIZESRSTAT_DEF,
   parameter int unsigned CLK_DIV       = 4,
   parameter int unsigned N_CYCLES_IDLE = 200,
   parameter int unsigned GAP_CYCLES    = 8
) (
   input  logic               CLK,
   input  logic               RST_N,
   sr_load_scheduler_if.slave bus
);

   localparam int unsigned BCNT_W  = $clog2(SIZESRSTAT + 1);
   localparam int unsigned CNT_MAX = (N_CYCLES_IDLE > GAP_CYCLES) ? N_CYCLES_IDLE : GAP_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   state_e                state_q;
   grant_e                last_grant_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [BCNT_W-1:0]     bits_q;
   logic [SIZESRSTAT-1:0] shreg_q;
   logic                  sel_q;
   logic                  mosi_q;
   logic                  busy_q;
   logic                  dyn_ack_q;
   logic                  stat_ack_q;
   logic                  done_dyn_q;
   logic                  done_stat_q;

   logic                  sclk_w;
   logic                  bit_start_c;
   logic                  bit_end_c;
   logic                  settle_last_c;
   logic                  gap_last_c;
   logic                  req_any_c;
   logic                  grant_dyn_c;
   logic [SIZESRSTAT-1:0] dyn_word_c;

   // Bit timing runs only while shifting so every transfer starts from a clean low half
   sr_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_bit_timer (
      .clk_i       (CLK),
      .rst_ni      (RST_N),
      .en_i        (state_q == SHIFT),
      .sclk_o      (sclk_w),
      .bit_start_c (bit_start_c),
      .bit_end_c   (bit_end_c)
   );

   // Shared cycle counter end conditions for the settle and gap windows
   assign settle_last_c = (32'(cnt_q) + 32'd1 >= N_CYCLES_IDLE);
   assign gap_last_c    = (32'(cnt_q) + 32'd1 >= GAP_CYCLES);

   // Round-robin: with both requests pending, the type not granted last wins
   assign req_any_c   = bus.dyn_req | bus.stat_req;
   assign grant_dyn_c = bus.dyn_req & (~bus.stat_req | (last_grant_q == STAT));

   // Dynamic word is left-aligned in the shared shift register
   assign dyn_word_c = SIZESRSTAT'(bus.dyn_data) << (SIZESRSTAT - SIZESRDYN);

   // Scheduler FSM with registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= SETTLE;
         last_grant_q <= STAT;
         cnt_q        <= '0;
         bits_q       <= '0;
         shreg_q      <= '0;
         sel_q        <= 1'b0;
         mosi_q       <= 1'b0;
         busy_q       <= 1'b1;
         dyn_ack_q    <= 1'b0;
         stat_ack_q   <= 1'b0;
         done_dyn_q   <= 1'b0;
         done_stat_q  <= 1'b0;
      end else begin
         dyn_ack_q   <= 1'b0;
         stat_ack_q  <= 1'b0;
         done_dyn_q  <= 1'b0;
         done_stat_q <= 1'b0;
         case (state_q)
            SETTLE: begin
               if (settle_last_c) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            IDLE: begin
               if (req_any_c) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
                  if (grant_dyn_c) begin
                     last_grant_q <= DYN;
                     sel_q        <= 1'b1;
                     dyn_ack_q    <= 1'b1;
                     shreg_q      <= dyn_word_c;
                     mosi_q       <= bus.dyn_data[SIZESRDYN-1];
                     bits_q       <= BCNT_W'(SIZESRDYN);
                  end else begin
                     last_grant_q <= STAT;
                     sel_q        <= 1'b0;
                     stat_ack_q   <= 1'b1;
                     shreg_q      <= bus.stat_data;
                     mosi_q       <= bus.stat_data[SIZESRSTAT-1];
                     bits_q       <= BCNT_W'(SIZESRSTAT);
                  end
               end
            end
            LOAD: begin
               state_q <= SHIFT;
            end
            SHIFT: begin
               // bits_q holds the bits still to start; zero at a bit end means the word is out
               if (bit_start_c && (bits_q != '0)) begin
                  bits_q <= bits_q - BCNT_W'(1);
               end
               if (bit_end_c) begin
                  if (bits_q == '0) begin
                     state_q <= GAP;
                     cnt_q   <= '0;
                     mosi_q  <= 1'b0;
                     if (last_grant_q == DYN) begin
                        done_dyn_q  <= 1'b1;
                     end else begin
                        done_stat_q <= 1'b1;
                     end
                  end else begin
                     mosi_q  <= shreg_q[SIZESRSTAT-2];
                     shreg_q <= shreg_q << 1;
                  end
               end
            end
            GAP: begin
               if (gap_last_c) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= SETTLE;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.SEL       = sel_q;
   assign bus.MOSI      = mosi_q;
   assign bus.SCLK      = sclk_w;
   assign bus.busy      = busy_q;
   assign bus.dyn_ack   = dyn_ack_q;
   assign bus.stat_ack  = stat_ack_q;
   assign bus.done_dyn  = done_dyn_q;
   assign bus.done_stat = done_stat_q;

endmodule
